// File: rtl/anton_neopixel_apb_bridge.sv
// APB4 slave that serialises each 32-bit word access into four byte-lane strobes
// on the neopixel controller byte bus, gathering read bytes back into PRDATA.
module anton_neopixel_apb_bridge #(
  parameter int READ_LATENCY = 1
) (
  input  logic        busClk,
  input  logic        busReset,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [15:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [13:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut
);

  typedef enum logic [2:0] {IDLE, XFER, DRAIN, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [1:0]  lane, lane_nxt;
  logic [1:0]  drain_cnt;
  logic [11:0] word_addr;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        aborted, aborted_nxt;
  logic [31:0] rdata, rdata_nxt;

  // Delay line tracking which lane's read data arrives READ_LATENCY cycles later.
  logic [READ_LATENCY-1:0] cap_vld;
  logic [1:0]              cap_lane [READ_LATENCY];

  logic        setup;
  logic        bad_addr;
  logic [11:0] src_addr;
  logic        src_wr;
  logic [31:0] src_wdata;
  logic [3:0]  src_strb;
  logic [13:0] bus_addr_nxt;
  logic [7:0]  bus_din_nxt;
  logic        bus_wr_nxt;
  logic        bus_rd_nxt;

  assign setup    = PSEL && !PENABLE;
  assign bad_addr = (PADDR[15:14] != 2'b00) || (PADDR[1:0] != 2'b00);

  // Lane 0 is launched on the same edge that latches the request, so take it straight from APB.
  assign src_addr  = (state == IDLE) ? PADDR[13:2] : word_addr;
  assign src_wr    = (state == IDLE) ? PWRITE      : wr_q;
  assign src_wdata = (state == IDLE) ? PWDATA      : wdata_q;
  assign src_strb  = (state == IDLE) ? PSTRB       : strb_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    state_nxt    = state;
    lane_nxt     = (state == XFER) ? lane + 2'd1 : 2'd0;
    aborted_nxt  = aborted;
    rdata_nxt    = rdata;
    bus_addr_nxt = busAddr;
    bus_din_nxt  = busDataIn;
    bus_wr_nxt   = 1'b0;
    bus_rd_nxt   = 1'b0;

    if (state == IDLE) aborted_nxt = 1'b0;
    else if ((state == XFER || state == DRAIN) && !PSEL) aborted_nxt = 1'b1;

    case (state)
      IDLE:  if (setup) state_nxt = bad_addr ? ERR : XFER;
      XFER:  if (lane == 2'd3) state_nxt = DRAIN;
      DRAIN: if (drain_cnt == 2'(READ_LATENCY - 1)) state_nxt = aborted_nxt ? IDLE : DONE;
      DONE:  state_nxt = IDLE;
      ERR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == XFER) begin
      bus_addr_nxt = {src_addr, lane_nxt};
      if (src_wr) begin
        bus_din_nxt = src_wdata[8*lane_nxt +: 8];
        bus_wr_nxt  = src_strb[lane_nxt];
      end else begin
        bus_din_nxt = 8'h00;
        bus_rd_nxt  = 1'b1;
      end
    end

    if (state == IDLE && setup) rdata_nxt = 32'h0;
    if (cap_vld[READ_LATENCY-1]) rdata_nxt[8*cap_lane[READ_LATENCY-1] +: 8] = busDataOut;
  end

  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      state     <= IDLE;
      lane      <= 2'd0;
      drain_cnt <= 2'd0;
      word_addr <= 12'h0;
      wr_q      <= 1'b0;
      wdata_q   <= 32'h0;
      strb_q    <= 4'h0;
      aborted   <= 1'b0;
      rdata     <= 32'h0;
      cap_vld   <= '0;
      // NOTE: the lane delay line is tiny, so it is reset along with everything else.
      for (int i = 0; i < READ_LATENCY; i++) cap_lane[i] <= 2'd0;
      PRDATA    <= 32'h0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      busAddr   <= 14'h0;
      busDataIn <= 8'h00;
      busWrite  <= 1'b0;
      busRead   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_nxt;
      lane      <= lane_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      aborted   <= aborted_nxt;
      rdata     <= rdata_nxt;
      if (state == IDLE && setup) begin
        word_addr <= PADDR[13:2];
        wr_q      <= PWRITE;
        wdata_q   <= PWDATA;
        strb_q    <= PSTRB;
      end
      cap_vld[0]  <= busRead;
      cap_lane[0] <= busAddr[1:0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        cap_vld[i]  <= cap_vld[i-1];
        cap_lane[i] <= cap_lane[i-1];
      end
      PRDATA    <= (state_nxt == DONE && !wr_q) ? rdata_nxt : 32'h0;
      PREADY    <= (state_nxt == DONE) || (state_nxt == ERR);
      PSLVERR   <= (state_nxt == ERR);
      busAddr   <= bus_addr_nxt;
      busDataIn <= bus_din_nxt;
      busWrite  <= bus_wr_nxt;
      busRead   <= bus_rd_nxt;
    end
  end

endmodule

// File: tb/tb_anton_neopixel_apb_bridge.sv
// Directed bench for the APB-to-byte-bus bridge: one instance at READ_LATENCY=1,
// one at READ_LATENCY=2, both served by a byte-memory model with latency matching its DUT.
module tb_anton_neopixel_apb_bridge;

  logic        clk, rst;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        cur;
  logic        model_init;

  logic        psel_a, psel_b;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;
  logic [13:0] addr_a, addr_b;
  logic [7:0]  din_a, din_b, dout_a, dout_b, b_d1;
  logic        wr_a, wr_b, rd_a, rd_b;

  logic [31:0] prdata;
  logic        pready, pslverr, bus_wr, bus_rd;
  logic [13:0] bus_addr;
  logic [7:0]  bus_din;

  logic [7:0]  mem [16384];

  int checks = 0;
  int failures = 0;

  assign psel_a   = psel && !cur;
  assign psel_b   = psel && cur;
  assign prdata   = cur ? prdata_b  : prdata_a;
  assign pready   = cur ? pready_b  : pready_a;
  assign pslverr  = cur ? pslverr_b : pslverr_a;
  assign bus_addr = cur ? addr_b    : addr_a;
  assign bus_din  = cur ? din_b     : din_a;
  assign bus_wr   = cur ? wr_b      : wr_a;
  assign bus_rd   = cur ? rd_b      : rd_a;

  anton_neopixel_apb_bridge #(.READ_LATENCY(1)) dut_a (
    .busClk(clk), .busReset(rst), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata_a), .PREADY(pready_a),
    .PSLVERR(pslverr_a), .busAddr(addr_a), .busDataIn(din_a), .busWrite(wr_a),
    .busRead(rd_a), .busDataOut(dout_a)
  );

  anton_neopixel_apb_bridge #(.READ_LATENCY(2)) dut_b (
    .busClk(clk), .busReset(rst), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata_b), .PREADY(pready_b),
    .PSLVERR(pslverr_b), .busAddr(addr_b), .busDataIn(din_b), .busWrite(wr_b),
    .busRead(rd_b), .busDataOut(dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: idle read data is 0xEE so a mistimed capture shows up as a wrong byte.
  always @(posedge clk) begin
    if (model_init) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem[14'h2000] <= 8'h1F;
      mem[14'h2001] <= 8'h00;
      mem[14'h2002] <= 8'h05;
      mem[14'h2003] <= 8'h01;
    end else begin
      if (wr_a) mem[addr_a] <= din_a;
      if (wr_b) mem[addr_b] <= din_b;
    end
    dout_a <= rd_a ? mem[addr_a] : 8'hEE;
    b_d1   <= rd_b ? mem[addr_b] : 8'hEE;
    dout_b <= b_d1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] wr_mask, rd_mask;
  logic [55:0] addr_seq;
  logic [31:0] din_seq;
  logic [33:0] c0_out;
  int          ready_cyc;
  logic [31:0] ready_data;
  logic        ready_err;

  // Drives one APB transfer starting at posedge+1; cycle k is sampled at its negedge.
  task automatic run(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input int drop_at);
    wr_mask = '0; rd_mask = '0; addr_seq = '0; din_seq = '0; c0_out = '0;
    ready_cyc = -1; ready_data = '0; ready_err = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      wr_mask[k] = bus_wr;
      rd_mask[k] = bus_rd;
      if (k == 0) c0_out = {pready, pslverr, prdata};
      if (k >= 1 && k <= 4) begin
        addr_seq = {addr_seq[41:0], bus_addr};
        din_seq  = {din_seq[23:0], bus_din};
      end
      if (pready && ready_cyc < 0) begin
        ready_cyc  = k;
        ready_data = prdata;
        ready_err  = pslverr;
      end
      @(posedge clk); #1;
      if (ready_cyc >= 0) break;
      penable = 1'b1;
      if (drop_at > 0 && k + 1 >= drop_at) begin
        psel = 1'b0; penable = 1'b0;
      end
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic watch(input int n, output int strobes, output int readies);
    strobes = 0; readies = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      strobes += int'(bus_wr) + int'(bus_rd);
      readies += int'(pready);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r;
    rst = 1'b1; model_init = 1'b1; cur = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    @(posedge clk); #1 model_init = 1'b0;
    check("reset_a", {prdata_a, pready_a, pslverr_a, addr_a, din_a, wr_a, rd_a}, 64'h0);
    check("reset_b", {prdata_b, pready_b, pslverr_b, addr_b, din_b, wr_b, rd_b}, 64'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Full-strobe write
    run(1'b1, 16'h0004, 32'hDDCCBBAA, 4'hF, 0);
    check("w_wrmask", wr_mask, 16'h001E);
    check("w_rdmask", rd_mask, 16'h0000);
    check("w_addr", addr_seq, {14'h0004, 14'h0005, 14'h0006, 14'h0007});
    check("w_din", din_seq, 32'hAABBCCDD);
    check("w_ready", ready_cyc, 6);
    check("w_resp", {ready_err, ready_data}, 33'h0);
    @(posedge clk); #1;

    // Read with the model returning 1F,00,05,01, then a back-to-back partial write
    run(1'b0, 16'h2000, 32'h0, 4'h0, 0);
    check("r_rdmask", rd_mask, 16'h001E);
    check("r_wrmask", wr_mask, 16'h0000);
    check("r_addr", addr_seq, {14'h2000, 14'h2001, 14'h2002, 14'h2003});
    check("r_din", din_seq, 32'h0);
    check("r_ready", ready_cyc, 6);
    check("r_resp", {ready_err, ready_data}, {1'b0, 32'h0105001F});
    run(1'b1, 16'h0010, 32'h44332211, 4'b0101, 0);
    check("b2b_c0", c0_out, 34'h0);
    check("p_wrmask", wr_mask, 16'h000A);
    check("p_din", din_seq, 32'h11223344);
    check("p_ready", ready_cyc, 6);

    // Readbacks show which lanes the model actually wrote
    run(1'b0, 16'h0010, 32'h0, 4'hF, 0);
    check("rb_partial", ready_data, 32'h49334B11);
    run(1'b0, 16'h0004, 32'h0, 4'h0, 0);
    check("rb_full", ready_data, 32'hDDCCBBAA);

    // PSTRB=0 write: no strobes, normal timing, memory untouched
    run(1'b1, 16'h0004, 32'h12345678, 4'h0, 0);
    check("z_wrmask", wr_mask, 16'h0000);
    check("z_ready", ready_cyc, 6);
    run(1'b0, 16'h0004, 32'h0, 4'h0, 0);
    check("z_readback", ready_data, 32'hDDCCBBAA);

    // Error decodes
    run(1'b1, 16'h4000, 32'hFFFFFFFF, 4'hF, 0);
    check("e1_ready", ready_cyc, 1);
    check("e1_resp", {ready_err, ready_data}, {1'b1, 32'h0});
    watch(6, s, r);
    check("e1_strobes", {wr_mask, rd_mask, 16'(s)}, 48'h0);
    run(1'b0, 16'h0002, 32'h0, 4'h0, 0);
    check("e2_ready", ready_cyc, 1);
    check("e2_resp", {ready_err, ready_data}, {1'b1, 32'h0});
    watch(6, s, r);
    check("e2_strobes", {wr_mask, rd_mask, 16'(s)}, 48'h0);

    // PSEL dropped mid-transfer: lanes complete, no PREADY; next read is clean
    run(1'b0, 16'h2000, 32'h0, 4'h0, 3);
    check("drop_rdmask", rd_mask, 16'h001E);
    check("drop_ready", ready_cyc, -1);
    run(1'b0, 16'h2000, 32'h0, 4'h0, 0);
    check("drop_after", {ready_cyc[7:0], ready_data}, {8'd6, 32'h0105001F});

    // PENABLE without a setup cycle is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0000; pstrb = 4'hF;
    watch(4, s, r);
    check("noset_quiet", {16'(s), 16'(r)}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    // Reset in cycle 2 of a read
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h2000;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    check("rst_pre", {bus_rd, bus_addr}, {1'b1, 14'h2001});
    #2 rst = 1'b1;
    #1 check("rst_async", {prdata, pready, pslverr, bus_addr, bus_din, bus_wr, bus_rd}, 64'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    watch(3, s, r);
    check("rst_quiet", {16'(s), 16'(r)}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    run(1'b0, 16'h2000, 32'h0, 4'h0, 0);
    check("rst_fresh", {ready_cyc[7:0], ready_err, ready_data}, {8'd6, 1'b0, 32'h0105001F});

    // READ_LATENCY=2: back-to-back read then write, then readback
    cur = 1'b1;
    @(posedge clk); #1;
    run(1'b0, 16'h2000, 32'h0, 4'h0, 0);
    check("l2_r_ready", ready_cyc, 7);
    check("l2_r_data", {ready_err, ready_data}, {1'b0, 32'h0105001F});
    check("l2_r_rdmask", rd_mask, 16'h001E);
    run(1'b1, 16'h0020, 32'h87654321, 4'hF, 0);
    check("l2_b2b_c0", c0_out, 34'h0);
    check("l2_w_ready", ready_cyc, 7);
    check("l2_w_wrmask", wr_mask, 16'h001E);
    check("l2_w_addr", addr_seq, {14'h0020, 14'h0021, 14'h0022, 14'h0023});
    run(1'b0, 16'h0020, 32'h0, 4'h0, 0);
    check("l2_readback", {ready_cyc[7:0], ready_data}, {8'd7, 32'h87654321});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
